// File: rtl/array_drain.sv
// rtl/array_drain.sv - snapshot and stream-out drain for the SIMD MAC array lane results
module array_drain #(
  parameter int LANES = 64,
  parameter int LPB   = 4,
  parameter int DW    = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     iC [LANES-1:0],
  input  logic              iStart,
  output logic              oBusy,
  output logic [LPB*DW-1:0] oData,
  output logic              oValid,
  input  logic              iReady,
  output logic              oLast,
  output logic              oDone
);

  localparam int BEATS = LANES / LPB;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t              state, state_nxt;
  logic [CW-1:0]       cnt, nxt_cnt;
  logic [DW-1:0]       snap [LANES-1:0];
  logic                capture, accept, at_last;
  logic [LPB*DW-1:0]   first_beat, next_beat;

  assign at_last = (cnt == LAST_CNT);
  assign nxt_cnt = at_last ? '0 : cnt + 1'b1;
  assign oLast   = oValid && at_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and decoded handshake/status outputs
  always_comb begin
    state_nxt = state;
    oBusy     = 1'b0;
    oValid    = 1'b0;
    oDone     = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (iStart) begin
          capture   = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        oBusy  = 1'b1;
        oValid = 1'b1;
        accept = iReady;
        if (iReady && at_last) state_nxt = DONE;
      end
      DONE: begin
        oDone     = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat 0 comes straight from the array so it is ready the cycle after capture;
  // later beats come from the frozen snapshot at the following counter value.
  always_comb begin
    first_beat = '0;
    next_beat  = '0;
    for (int i = 0; i < LPB; i++) begin
      first_beat[i*DW +: DW] = iC[IW'(i)];
      next_beat[i*DW +: DW]  = snap[IW'(int'(nxt_cnt) * LPB + i)];
    end
  end

  // Snapshot, beat counter and registered output beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      oData <= '0;
      for (int i = 0; i < LANES; i++) snap[i] <= '0;
    end else if (capture) begin
      cnt   <= '0;
      oData <= first_beat;
      for (int i = 0; i < LANES; i++) snap[i] <= iC[i];
    end else if (accept) begin
      cnt   <= nxt_cnt;
      oData <= at_last ? '0 : next_beat;
    end
  end

endmodule

// File: tb/tb_array_drain.sv
// tb/tb_array_drain.sv - scoreboard bench for array_drain (LPB 4, 1 and 64 instances)
module tb_array_drain;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ic [63:0];
  logic        start_main, start_sweep, ready;

  logic         busy_m, valid_m, last_m, done_m;
  logic [127:0] data_m;
  logic         busy_1, valid_1, last_1, done_1;
  logic [31:0]  data_1;
  logic         busy_a, valid_a, last_a, done_a;
  logic [2047:0] data_a;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]   sbq [3][$];
  int            hs [3];
  int            dones [3];
  bit            stalled [3];
  logic [2047:0] prev [3];
  logic          done_s [3];

  assign done_s[0] = done_m;
  assign done_s[1] = done_1;
  assign done_s[2] = done_a;

  always #5 clk = ~clk;

  array_drain #(.LANES(64), .LPB(4), .DW(32)) u_main (
    .clk(clk), .rst_n(rst_n), .iC(ic), .iStart(start_main), .oBusy(busy_m),
    .oData(data_m), .oValid(valid_m), .iReady(ready), .oLast(last_m), .oDone(done_m));

  array_drain #(.LANES(64), .LPB(1), .DW(32)) u_one (
    .clk(clk), .rst_n(rst_n), .iC(ic), .iStart(start_sweep), .oBusy(busy_1),
    .oData(data_1), .oValid(valid_1), .iReady(ready), .oLast(last_1), .oDone(done_1));

  array_drain #(.LANES(64), .LPB(64), .DW(32)) u_all (
    .clk(clk), .rst_n(rst_n), .iC(ic), .iStart(start_sweep), .oBusy(busy_a),
    .oData(data_a), .oValid(valid_a), .iReady(ready), .oLast(last_a), .oDone(done_a));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon(input int id, input int lpb, input logic [2047:0] data,
                     input logic valid, input logic rdy, input logic last, input logic done);
    if (!rst_n) begin
      stalled[id] = 1'b0;
      return;
    end
    if (valid && stalled[id]) check($sformatf("stable%0d", id), 64'(data == prev[id]), 64'd1);
    if (!valid) begin
      check($sformatf("idle_data%0d", id), 64'(data == '0), 64'd1);
      check($sformatf("idle_last%0d", id), 64'(last), 64'd0);
    end
    if (valid && rdy) begin
      for (int j = 0; j < lpb; j++) begin
        if (sbq[id].size() == 0) check($sformatf("extra_beat%0d", id), 64'd0, 64'd1);
        else check($sformatf("lane%0d_%0d", id, j), 64'(data[j*32 +: 32]), 64'(sbq[id].pop_front()));
      end
      check($sformatf("last%0d", id), 64'(last), 64'(sbq[id].size() == 0));
      hs[id]++;
    end
    stalled[id] = valid && !rdy;
    prev[id]    = data;
    if (done) begin
      dones[id]++;
      check($sformatf("done_valid%0d", id), 64'(valid), 64'd0);
    end
  endtask

  always @(negedge clk) mon(0, 4,  2048'(data_m), valid_m, ready, last_m, done_m);
  always @(negedge clk) mon(1, 1,  2048'(data_1), valid_1, ready, last_1, done_1);
  always @(negedge clk) mon(2, 64, data_a,        valid_a, ready, last_a, done_a);

  task automatic clr();
    for (int k = 0; k < 3; k++) begin
      hs[k] = 0;
      dones[k] = 0;
    end
  endtask

  task automatic push(input int id);
    for (int i = 0; i < 64; i++) sbq[id].push_back(ic[i]);
  endtask

  task automatic pulse_main();
    start_main = 1'b1;
    @(posedge clk); #1;
    start_main = 1'b0;
    check("first_valid", 64'(valid_m), 64'd1);
    check("first_busy", 64'(busy_m), 64'd1);
  endtask

  task automatic wait_done(input int id, input int maxc, input bit rnd, output int cycles);
    cycles = 0;
    for (int c = 0; c < maxc; c++) begin
      @(posedge clk); #1;
      cycles++;
      if (rnd) ready = 1'($urandom_range(0, 1));
      if (done_s[id]) begin
        ready = 1'b1;
        return;
      end
    end
    check($sformatf("timeout%0d", id), 64'd0, 64'd1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; ready = 1'b0; start_main = 1'b0; start_sweep = 1'b0;
    for (int i = 0; i < 64; i++) ic[i] = '0;
    clr();
    #3;
    check("rst_busy", 64'(busy_m), 64'd0);
    check("rst_valid", 64'(valid_m), 64'd0);
    check("rst_last", 64'(last_m), 64'd0);
    check("rst_done", 64'(done_m), 64'd0);
    check("rst_data", 64'(data_m[63:0]), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic, ready held high
    for (int i = 0; i < 64; i++) ic[i] = 32'(i + 1);
    clr(); ready = 1'b1; push(0);
    pulse_main();
    check("t1_beat0", 64'(data_m[63:0]), {32'd2, 32'd1});
    wait_done(0, 100, 1'b0, cyc);
    check("t1_cycles", 64'(cyc), 64'd16);
    check("t1_busy_done", 64'(busy_m), 64'd0);
    @(posedge clk); #1;
    check("t1_done_once", 64'(done_m), 64'd0);
    check("t1_hs", 64'(hs[0]), 64'd16);
    check("t1_dones", 64'(dones[0]), 64'd1);

    // 2: random backpressure
    for (int i = 0; i < 64; i++) ic[i] = 32'h0000A000 + 32'(i);
    clr(); ready = 1'b0; push(0);
    pulse_main();
    wait_done(0, 600, 1'b1, cyc);
    @(posedge clk); #1;
    check("t2_hs", 64'(hs[0]), 64'd16);
    check("t2_dones", 64'(dones[0]), 64'd1);

    // 3: snapshot isolation
    for (int i = 0; i < 64; i++) ic[i] = 32'(i);
    clr(); ready = 1'b1; push(0);
    pulse_main();
    for (int i = 0; i < 64; i++) ic[i] = 32'h0000FFFF;
    wait_done(0, 100, 1'b0, cyc);
    @(posedge clk); #1;
    check("t3_hs", 64'(hs[0]), 64'd16);

    // 4: start while busy is ignored; start in DONE ignored, in IDLE accepted
    for (int i = 0; i < 64; i++) ic[i] = 32'(i * 3);
    clr(); push(0);
    pulse_main();
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 64; i++) ic[i] = 32'(i + 100);
    start_main = 1'b1;
    @(posedge clk); #1;
    start_main = 1'b0;
    wait_done(0, 100, 1'b0, cyc);
    for (int i = 0; i < 64; i++) ic[i] = 32'(i + 200);
    push(0);
    start_main = 1'b1;
    @(posedge clk); #1;
    check("t4_done_ignored", 64'(busy_m), 64'd0);
    @(posedge clk); #1;
    start_main = 1'b0;
    check("t4_restart", 64'(valid_m), 64'd1);
    wait_done(0, 100, 1'b0, cyc);
    @(posedge clk); #1;
    check("t4_hs", 64'(hs[0]), 64'd32);
    check("t4_dones", 64'(dones[0]), 64'd2);

    // 5: reset mid-drain
    for (int i = 0; i < 64; i++) ic[i] = 32'(i + 7);
    clr(); push(0);
    pulse_main();
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_valid", 64'(valid_m), 64'd0);
    check("t5_busy", 64'(busy_m), 64'd0);
    check("t5_last", 64'(last_m), 64'd0);
    check("t5_data", 64'(data_m[63:0]), 64'd0);
    check("t5_hs", 64'(hs[0]), 64'd7);
    sbq[0].delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5_no_done", 64'(dones[0]), 64'd0);
    for (int i = 0; i < 64; i++) ic[i] = 32'(i) ^ 32'h55;
    clr(); push(0);
    pulse_main();
    wait_done(0, 100, 1'b0, cyc);
    @(posedge clk); #1;
    check("t5_hs_after", 64'(hs[0]), 64'd16);

    // 6: parameter sweep LPB=1 and LPB=64
    for (int i = 0; i < 64; i++) ic[i] = 32'(i * 5 + 1);
    clr(); push(1); push(2);
    start_sweep = 1'b1;
    @(posedge clk); #1;
    start_sweep = 1'b0;
    check("t6_all_last", 64'(last_a), 64'd1);
    wait_done(1, 200, 1'b0, cyc);
    @(posedge clk); #1;
    check("t6_hs1", 64'(hs[1]), 64'd64);
    check("t6_hs64", 64'(hs[2]), 64'd1);
    check("t6_dones1", 64'(dones[1]), 64'd1);
    check("t6_dones64", 64'(dones[2]), 64'd1);
    check("t6_left", 64'(sbq[0].size() + sbq[1].size() + sbq[2].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
